// File: rtl/hpdcache_sram_ctrl.sv
// hpdcache_sram_ctrl: zero-init sweep plus valid/ready front end for hpdcache_sram.
// Define HPDCACHE_SRAM_RDATA_REG_EN to register sram_rdata (read latency 3).
module hpdcache_sram_ctrl #(
   parameter int ADDR_SIZE = 6,
   parameter int DATA_SIZE = 64,
   parameter int DEPTH     = 2**ADDR_SIZE
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 init_req,
   output logic                 init_done,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [ADDR_SIZE-1:0] req_addr,
   input  logic [DATA_SIZE-1:0] req_wdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [DATA_SIZE-1:0] rsp_rdata,
   output logic                 sram_cs,
   output logic                 sram_we,
   output logic [ADDR_SIZE-1:0] sram_addr,
   output logic [DATA_SIZE-1:0] sram_wdata,
   input  logic [DATA_SIZE-1:0] sram_rdata
);

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_e;

   localparam logic [ADDR_SIZE-1:0] LAST =
      ADDR_SIZE'(DEPTH - 1);

   state_e               state_q;
   logic [ADDR_SIZE-1:0] cnt_q;
   logic                 init_pend_q;
   logic                 init_done_q;
   logic                 rd1_q;
   logic                 rsp_valid_q;
   logic [DATA_SIZE-1:0] rsp_rdata_q;

   logic                 rd_inflight;
   logic                 capture;
   logic [DATA_SIZE-1:0] cap_data;
   logic                 run;
   logic                 init_go;
   logic                 req_acc;
   logic                 rd_acc;

`ifdef HPDCACHE_SRAM_RDATA_REG_EN
   logic                 rd2_q;
   logic [DATA_SIZE-1:0] rdata_q;

   assign rd_inflight = rd1_q | rd2_q;
   assign capture     = rd2_q;
   assign cap_data    = rdata_q;
`else
   assign rd_inflight = rd1_q;
   assign capture     = rd1_q;
   assign cap_data    = sram_rdata;
`endif

   assign run = (state_q == ST_RUN);

   // A pending init waits for the in-flight read to land first
   assign init_go = run
                  & (init_req | init_pend_q)
                  & ~rd_inflight;

   assign req_ready = run
                    & ~rd_inflight
                    & ~init_req
                    & ~init_pend_q
                    & (~rsp_valid_q | rsp_ready);

   assign req_acc = req_valid & req_ready;
   assign rd_acc  = req_acc & ~req_we;

   assign init_done = init_done_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;

   always_comb begin
      sram_cs    = 1'b0;
      sram_we    = 1'b0;
      sram_addr  = '0;
      sram_wdata = '0;
      if (!run) begin
         sram_cs   = 1'b1;
         sram_we   = 1'b1;
         sram_addr = cnt_q;
      end else if (req_acc) begin
         sram_cs    = 1'b1;
         sram_we    = req_we;
         sram_addr  = req_addr;
         sram_wdata = req_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_INIT;
         cnt_q       <= '0;
         init_pend_q <= 1'b0;
         init_done_q <= 1'b0;
         rd1_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
`ifdef HPDCACHE_SRAM_RDATA_REG_EN
         rd2_q       <= 1'b0;
         rdata_q     <= '0;
`endif
      end else begin
         rd1_q <= rd_acc;
`ifdef HPDCACHE_SRAM_RDATA_REG_EN
         rd2_q <= rd1_q;
         if (rd1_q) begin
            rdata_q <= sram_rdata;
         end
`endif
         if (capture) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= cap_data;
         end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end

         unique case (state_q)
            ST_INIT: begin
               if (cnt_q == LAST) begin
                  cnt_q       <= '0;
                  state_q     <= ST_RUN;
                  init_done_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_RUN: begin
               if (init_go) begin
                  state_q     <= ST_INIT;
                  init_done_q <= 1'b0;
                  init_pend_q <= 1'b0;
               end else if (init_req) begin
                  init_pend_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hpdcache_sram_ctrl.sv
// Bench for hpdcache_sram_ctrl: vector table, corner sequences, random traffic.
// Honours HPDCACHE_SRAM_RDATA_REG_EN for the expected read latency.
module tb_hpdcache_sram_ctrl;

   localparam int AW    = 6;
   localparam int DW    = 64;
   localparam int DEPTH = 64;
`ifdef HPDCACHE_SRAM_RDATA_REG_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          init_req = 1'b0;
   logic          init_done;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [DW-1:0] rsp_rdata;
   logic          sram_cs;
   logic          sram_we;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_wdata;
   logic [DW-1:0] sram_rdata;

   hpdcache_sram_ctrl #(
      .ADDR_SIZE(AW),
      .DATA_SIZE(DW),
      .DEPTH    (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .init_req  (init_req),
      .init_done (init_done),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .sram_cs   (sram_cs),
      .sram_we   (sram_we),
      .sram_addr (sram_addr),
      .sram_wdata(sram_wdata),
      .sram_rdata(sram_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // SRAM behaviour: 1-cycle read latency, filled with garbage at start
   logic [DW-1:0] mem [DEPTH];
   bit            seeded = 1'b0;
   always @(posedge clk) begin
      if (!seeded) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= {$urandom, $urandom};
         seeded <= 1'b1;
      end else if (sram_cs) begin
         if (sram_we) mem[sram_addr] <= sram_wdata;
         else         sram_rdata <= mem[sram_addr];
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk64(input string nm,
                        input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference model: memory contents and queue of expected read responses
   typedef struct {
      logic [DW-1:0] data;
      int            acc;
   } rsp_t;

   logic [DW-1:0] exp_mem [DEPTH];
   rsp_t          exp_q[$];
   bit            head_seen = 1'b0;
   bit            chk_ready = 1'b0;
   int            last_rd = -100;

   always @(negedge clk) begin : model
      bit acc;
      bit pend;
      bit exp_rdy;
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
         exp_q.delete();
         head_seen = 1'b0;
      end else begin
         if (init_req)
            for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
         acc = req_valid && req_ready;
         if (chk_ready) begin
            pend = exp_q.size() > 0 && cyc >= exp_q[0].acc + LAT;
            exp_rdy = (cyc - last_rd >= LAT)
                    && (!pend || rsp_ready) && !init_req;
            chk1("rnd_req_ready", req_ready, exp_rdy);
            chk1("rnd_sram_cs", sram_cs, acc);
            if (acc) begin
               chk1("rnd_sram_we", sram_we, req_we);
               chk64("rnd_sram_addr", 64'(sram_addr), 64'(req_addr));
               chk64("rnd_sram_wdata", sram_wdata, req_wdata);
            end else begin
               chk1("rnd_sram_we_idle", sram_we, 1'b0);
            end
         end
         if (acc) begin
            if (req_we) begin
               exp_mem[req_addr] = req_wdata;
            end else begin
               exp_q.push_back('{exp_mem[req_addr], cyc});
               last_rd = cyc;
            end
         end
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               chk1("rsp_spurious", rsp_valid, 1'b0);
            end else begin
               if (!head_seen) begin
                  chki("mdl_latency", cyc - exp_q[0].acc, LAT);
                  head_seen = 1'b1;
               end
               if (rsp_ready) begin
                  chk64("mdl_rdata", rsp_rdata, exp_q[0].data);
                  void'(exp_q.pop_front());
                  head_seen = 1'b0;
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output int acc);
      bit got;
      got = 1'b0;
      acc = -1;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (req_ready) begin
            got = 1'b1;
            acc = cyc;
         end
         step();
      end
      req_valid = 1'b0;
      if (!got) chk1("req_timeout", req_ready, 1'b1);
   endtask

   task automatic wait_rsp(input int acc, input logic [DW-1:0] exp,
                           input string nm);
      bit got;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk);
         if (rsp_valid) begin
            got = 1'b1;
            chki({nm, "_lat"}, cyc - acc, LAT);
            chk64({nm, "_data"}, rsp_rdata, exp);
         end
         step();
      end
      if (!got) chk1({nm, "_timeout"}, rsp_valid, 1'b1);
   endtask

   task automatic wait_done(input int c0, input string nm);
      bit got;
      got = 1'b0;
      for (int k = 0; k < DEPTH + 10 && !got; k++) begin
         @(negedge clk);
         if (init_done) begin
            got = 1'b1;
            chki({nm, "_len"}, cyc - c0, DEPTH);
         end
         step();
      end
      if (!got) chk1({nm, "_timeout"}, init_done, 1'b1);
   endtask

   typedef struct {
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp;
   } vec_t;

   vec_t vt[10];

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : driver
      int  acc;
      int  c0;
      bit  seen;
      bit  got;

      vt[0] = '{1'b1, 6'd5,  64'hDEAD_BEEF_0000_0001, 64'h0};
      vt[1] = '{1'b0, 6'd5,  64'h0, 64'hDEAD_BEEF_0000_0001};
      vt[2] = '{1'b0, 6'd6,  64'h0, 64'h0};
      vt[3] = '{1'b1, 6'd63, 64'h0123_4567_89AB_CDEF, 64'h0};
      vt[4] = '{1'b1, 6'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
      vt[5] = '{1'b0, 6'd63, 64'h0, 64'h0123_4567_89AB_CDEF};
      vt[6] = '{1'b0, 6'd0,  64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
      vt[7] = '{1'b1, 6'd5,  64'hA5A5_5A5A_0F0F_F0F0, 64'h0};
      vt[8] = '{1'b0, 6'd5,  64'h0, 64'hA5A5_5A5A_0F0F_F0F0};
      vt[9] = '{1'b0, 6'd1,  64'h0, 64'h0};

      // Reset state
      rst_n = 1'b0;
      repeat (3) step();
      @(negedge clk);
      chk1("rst_init_done", init_done, 1'b0);
      chk1("rst_rsp_valid", rsp_valid, 1'b0);
      chk64("rst_rsp_rdata", rsp_rdata, 64'h0);
      chk1("rst_req_ready", req_ready, 1'b0);
      step();

      // Init sweep with a request held valid throughout
      rst_n = 1'b1;
      req_valid = 1'b1;
      req_we = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         chk64("init_ctl",
               64'({sram_cs, sram_we, req_ready, init_done, sram_addr}),
               64'({1'b1, 1'b1, 1'b0, 1'b0, 6'(i)}));
         chk64("init_wdata", sram_wdata, 64'h0);
         step();
      end
      req_valid = 1'b0;
      @(negedge clk);
      chk1("init_done_rise", init_done, 1'b1);
      chk1("init_ready_rise", req_ready, 1'b1);
      step();

      // Vector table
      for (int i = 0; i < 10; i++) begin
         do_req(vt[i].we, vt[i].addr, vt[i].wdata, acc);
         if (!vt[i].we)
            wait_rsp(acc, vt[i].exp, $sformatf("vec%0d", i));
      end

      // Ready stays low while a read is in flight
      do_req(1'b0, 6'd5, 64'h0, acc);
      req_valid = 1'b1;
      req_we = 1'b0;
      req_addr = 6'd6;
      for (int k = 1; k < LAT; k++) begin
         @(negedge clk);
         chk1("rd_busy_ready", req_ready, 1'b0);
         step();
      end
      @(negedge clk);
      chk1("rd_free_ready", req_ready, 1'b1);
      step();
      req_valid = 1'b0;
      repeat (8) step();

      // Backpressure
      rsp_ready = 1'b0;
      do_req(1'b0, 6'd5, 64'h0, acc);
      wait_rsp(acc, 64'hA5A5_5A5A_0F0F_F0F0, "bp_first");
      req_valid = 1'b1;
      req_we = 1'b0;
      req_addr = 6'd63;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk1("bp_valid", rsp_valid, 1'b1);
         chk64("bp_data", rsp_rdata, 64'hA5A5_5A5A_0F0F_F0F0);
         chk1("bp_ready", req_ready, 1'b0);
         step();
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk1("bp_drain_accept", req_ready, 1'b1);
      acc = cyc;
      step();
      req_valid = 1'b0;
      wait_rsp(acc, 64'h0123_4567_89AB_CDEF, "bp_next");

      // init_req right after a read acceptance
      do_req(1'b0, 6'd63, 64'h0, acc);
      init_req = 1'b1;
      @(negedge clk);
      chk1("ir_ready_inflight", req_ready, 1'b0);
      seen = rsp_valid;
      step();
      init_req = 1'b0;
      got = 1'b0;
      c0 = -1;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk);
         if (rsp_valid) begin
            seen = 1'b1;
            chk64("ir_rsp_data", rsp_rdata, 64'h0123_4567_89AB_CDEF);
         end
         if (!init_done) begin
            got = 1'b1;
            c0 = cyc;
            chk64("ir_sweep_start",
                  64'({sram_cs, sram_we, sram_addr}),
                  64'({1'b1, 1'b1, 6'd0}));
         end
         step();
      end
      chk1("ir_done_drop", got, 1'b1);
      chki("ir_sweep_delay", c0 - acc, LAT + 1);
      wait_done(c0, "ir_sweep");
      chk1("ir_rsp_delivered", seen, 1'b1);
      do_req(1'b0, 6'd63, 64'h0, acc);
      wait_rsp(acc, 64'h0, "ir_zeroed");

      // Pending response held through sweep, then reset mid-sweep
      do_req(1'b1, 6'd7, 64'h1234_5678_9ABC_DEF0, acc);
      rsp_ready = 1'b0;
      do_req(1'b0, 6'd7, 64'h0, acc);
      wait_rsp(acc, 64'h1234_5678_9ABC_DEF0, "hold_first");
      init_req = 1'b1;
      step();
      init_req = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk1("hold_sweep_valid", rsp_valid, 1'b1);
         chk64("hold_sweep_data", rsp_rdata, 64'h1234_5678_9ABC_DEF0);
         step();
      end
      @(negedge clk);
      chk1("mid_sweep_done", init_done, 1'b0);
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk1("rst_mid_rsp_valid", rsp_valid, 1'b0);
      chk64("rst_mid_sweep",
            64'({sram_cs, sram_we, sram_addr}),
            64'({1'b1, 1'b1, 6'd0}));
      c0 = cyc;
      step();
      wait_done(c0, "rst_mid");
      do_req(1'b0, 6'd7, 64'h0, acc);
      wait_rsp(acc, 64'h0, "rst_zeroed");

      // Random traffic against the reference model
      chk_ready = 1'b1;
      for (int n = 0; n < 500; n++) begin
         req_valid = 1'($urandom_range(0, 1));
         req_we    = 1'($urandom_range(0, 1));
         req_addr  = 6'($urandom_range(0, 7));
         req_wdata = {$urandom, $urandom};
         rsp_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (8) step();
      chk_ready = 1'b0;
      @(negedge clk);
      chki("rnd_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/hpdcache_sram_ctrl.md
Name: hpdcache_sram_ctrl

Overview:
- Request/response controller placed directly upstream of hpdcache_sram; drives its cs/we/addr/wdata and captures its rdata.
- After reset, and on request, sweeps every SRAM word to zero.
- Then serves single-beat read/write requests over a valid/ready interface; reads return data on a valid/ready response channel.
- Gives cache pipelines a clean handshake instead of raw 1-cycle-latency SRAM timing.

Parameters:
- ADDR_SIZE, 6, SRAM address width.
- DATA_SIZE, 64, SRAM word width.
- DEPTH, 2**ADDR_SIZE, number of words swept by init (must be ≤ 2**ADDR_SIZE).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- init_req  in  1  pulse: re-run zero-initialisation sweep.
- init_done  out  1  1 when sweep complete and requests are accepted.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid&ready.
- req_we  in  1  1=write, 0=read.
- req_addr  in  ADDR_SIZE  word address.
- req_wdata  in  DATA_SIZE  write data.
- rsp_valid  out  1  read data valid.
- rsp_ready  in  1  consumer accepts read data.
- rsp_rdata  out  DATA_SIZE  read data.
- sram_cs  out  1  to hpdcache_sram cs.
- sram_we  out  1  to hpdcache_sram we.
- sram_addr  out  ADDR_SIZE  to hpdcache_sram addr.
- sram_wdata  out  DATA_SIZE  to hpdcache_sram wdata.
- sram_rdata  in  DATA_SIZE  from hpdcache_sram rdata; valid the cycle after a read with cs=1, we=0.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous and active-low.
- Reset values: state=INIT, init counter=0, rd_inflight=0, rsp_valid=0, rsp_rdata=0, init_done=0.
- States: INIT, RUN.
- INIT:
  - sram_cs=1, sram_we=1, sram_addr=cnt, sram_wdata=0 every cycle; cnt increments each cycle.
  - On the cycle cnt==DEPTH-1, the next state is RUN and cnt resets to 0.
  - The sweep takes exactly DEPTH cycles; init_done=1 from the first RUN cycle.
  - req_ready=0 throughout INIT.
- RUN:
  - req_ready = !rd_inflight && (!rsp_valid || rsp_ready); combinational, does not depend on req_valid.
  - On an accepted request, sram_cs=1, sram_we=req_we, sram_addr=req_addr, sram_wdata=req_wdata, in the same cycle (combinational pass-through).
  - Otherwise sram_cs=0 and sram_we=0.
  - Read accepted at cycle T: rd_inflight=1 during T+1; sram_rdata is captured into rsp_rdata at the end of T+1; rsp_valid=1 from T+2.
  - Read latency is 2 cycles from acceptance to rsp_valid.
  - rsp_valid and rsp_rdata hold stable until rsp_valid&rsp_ready; rsp_valid clears the following cycle unless a new capture lands.
  - Writes produce no response. A write accepted at T is visible to a read accepted at T+1 or later.
  - Throughput is at most one read every 2 cycles; writes may issue every cycle while no read is in flight.
  - Simultaneous rsp drain and new request acceptance in the same cycle is allowed.
- init_req:
  - Sampled only in RUN. If init_req=1 and rd_inflight=0, the next state is INIT and req_ready=0 that cycle.
  - If rd_inflight=1, the read completes first and init_req is held pending internally until rd_inflight=0.
  - A pending rsp_valid is retained through the sweep.
  - init_req in INIT is ignored and does not restart the counter.
- Reset mid-operation: any cycle with rst_n=0 returns to INIT with cnt=0. In-flight reads and pending responses are discarded (rsp_valid=0).
- sram outputs are don't-care only when sram_cs=0; drive 0 anyway.

Optional Feature:
- Macro: HPDCACHE_SRAM_RDATA_REG_EN.
- Defined:
  - sram_rdata passes through an extra pipeline register before capture into rsp_rdata.
  - rd_inflight covers 2 cycles (T+1, T+2).
  - rsp_valid rises at T+3; read latency is 3.
  - req_ready also stays 0 through T+2.
  - Read throughput is one every 3 cycles.
- Undefined: latency 2 as above, no extra register.

Test Plan:
- Reset release, DEPTH=64: sram_cs=we=1 for 64 cycles with addr 0..63 and wdata=0; init_done=1 at cycle 65; req_ready=0 before that.
- After init: write addr 5 data 0xDEAD_BEEF_0000_0001, then read addr 5 on the next cycle -> rsp_valid 2 cycles after read acceptance with rsp_rdata=0xDEAD_BEEF_0000_0001; read of addr 6 returns 0.
- Backpressure: read, rsp_ready=0 for 10 cycles -> rsp_valid held with stable data; req_ready=0; on rsp_ready=1 the same cycle a new read is accepted.
- init_req asserted one cycle after a read acceptance -> read response still delivered; sweep starts after rd_inflight clears; init_done drops, then re-asserts DEPTH cycles later.
- rst_n=0 for one cycle with rsp_valid=1 mid-sweep -> rsp_valid=0, sweep restarts at addr 0.
- With HPDCACHE_SRAM_RDATA_REG_EN: read accepted at T -> rsp_valid at T+3 with correct data; req_ready low through T+2.
